// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: instruction length encoding and fetch FSM states.
package cpu_pkg;

  typedef logic [1:0] op_len_t;

  localparam op_len_t OP_LEN_1 = 2'd1;
  localparam op_len_t OP_LEN_2 = 2'd2;
  localparam op_len_t OP_LEN_3 = 2'd3;

  localparam logic [7:0] INT_IR_NATIVE_HI = 8'h00;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_DROP = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/op_len_decode.sv
// 6502/65C02 instruction length from the opcode byte (1..3 bytes), combinational.
module op_len_decode
  import cpu_pkg::*;
(
  input  logic [7:0] i_opcode,
  output op_len_t    o_len
);

  always_comb begin
    o_len = OP_LEN_2;
    if (i_opcode[3:2] == 2'b11 || i_opcode[4:0] == 5'b11001 || i_opcode == 8'h20) begin
      o_len = OP_LEN_3;
    end else if (i_opcode[3:0] == 4'h8 || i_opcode[3:0] == 4'hA ||
                 i_opcode[3:0] == 4'h3 || i_opcode[3:0] == 4'hB ||
                 i_opcode == 8'h40 || i_opcode == 8'h60) begin
      o_len = OP_LEN_1;
    end
  end

endmodule

// File: rtl/ir_feed.sv
// Instruction feed: byte prefetch FIFO, instruction assembly into IR/K words,
// and sequencer interrupt-word injection ahead of decode.
module ir_feed
  import cpu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] RESET_PC   = 16'h0000
) (
  input  logic        clk,
  input  logic        a_rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  input  logic        pc_load,
  input  logic [15:0] pc_new,
  input  logic        hold_fetch,
  input  logic        replace_ir,
  input  logic        replace_k,
  input  logic [15:0] int_ir,
  input  logic [15:0] int_k,
  output logic        feed_valid,
  output logic [15:0] feed_ir,
  output logic [15:0] feed_k,
  output logic [15:0] feed_pc,
  input  logic        feed_ready,
  output logic        feed_ack
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  logic [7:0]   r_fifo [FIFO_DEPTH];
  ptr_t         r_rd_ptr, r_wr_ptr;
  cnt_t         r_count;
  fetch_state_t r_state, w_state_nxt;
  logic         r_mem_req;
  logic [15:0]  r_mem_addr, r_redirect, r_head_pc;
  logic         r_feed_valid;
  logic [15:0]  r_feed_ir, r_feed_k, r_feed_pc;

  logic [7:0]   w_b0, w_b1, w_b2;
  op_len_t      w_len;
  logic         w_push, w_load, w_ack;

  assign w_b0 = r_fifo[r_rd_ptr];
  assign w_b1 = r_fifo[r_rd_ptr + ptr_t'(1)];
  assign w_b2 = r_fifo[r_rd_ptr + ptr_t'(2)];

  op_len_decode u_len (
    .i_opcode (w_b0),
    .o_len    (w_len)
  );

  assign w_ack  = r_feed_valid & feed_ready & ~pc_load;
  assign w_push = (r_state == FETCH_RUN) && r_mem_req && mem_ack && !pc_load;
  assign w_load = !hold_fetch && !replace_ir && !pc_load &&
                  (r_count >= cnt_t'(w_len)) && (!r_feed_valid || w_ack);

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) r_state <= FETCH_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FETCH_RUN:  if (pc_load && r_mem_req && !mem_ack) w_state_nxt = FETCH_DROP;
      FETCH_DROP: if (mem_ack) w_state_nxt = FETCH_RUN;
    endcase
  end

  // A redirect never moves the address of an in-flight request; the target
  // is parked in r_redirect until the stale byte has been retired.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_redirect <= RESET_PC;
    end else begin
      unique case (r_state)
        FETCH_RUN: begin
          if (pc_load) begin
            if (r_mem_req && !mem_ack) begin
              r_redirect <= pc_new;
            end else begin
              r_mem_addr <= pc_new;
              r_mem_req  <= 1'b1;
            end
          end else if (r_mem_req) begin
            if (mem_ack) begin
              r_mem_req  <= 1'b0;
              r_mem_addr <= r_mem_addr + 16'd1;
            end
          end else begin
            r_mem_req <= (r_count < cnt_t'(FIFO_DEPTH));
          end
        end
        FETCH_DROP: begin
          if (mem_ack) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= pc_load ? pc_new : r_redirect;
          end else if (pc_load) begin
            r_redirect <= pc_new;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= mem_data;
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (pc_load) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + ptr_t'(w_len);
      r_count <= r_count + (w_push ? cnt_t'(1) : '0) - (w_load ? cnt_t'(w_len) : '0);
    end
  end

  // Injection takes priority over both the redirect clear and a native load.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_head_pc    <= RESET_PC;
      r_feed_valid <= 1'b0;
      r_feed_ir    <= '0;
      r_feed_k     <= '0;
      r_feed_pc    <= '0;
    end else begin
      if (pc_load)     r_head_pc <= pc_new;
      else if (w_load) r_head_pc <= r_head_pc + {14'd0, w_len};

      if (replace_ir) begin
        r_feed_valid <= 1'b1;
        r_feed_ir    <= int_ir;
        r_feed_pc    <= pc_load ? pc_new : r_head_pc;
        if (replace_k) r_feed_k <= int_k;
      end else if (pc_load) begin
        r_feed_valid <= 1'b0;
      end else if (w_load) begin
        r_feed_valid <= 1'b1;
        r_feed_ir    <= {INT_IR_NATIVE_HI, w_b0};
        r_feed_pc    <= r_head_pc;
        unique case (w_len)
          OP_LEN_3: r_feed_k <= {w_b2, w_b1};
          OP_LEN_2: r_feed_k <= {8'h00, w_b1};
          default:  r_feed_k <= '0;
        endcase
      end else if (w_ack) begin
        r_feed_valid <= 1'b0;
      end
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign feed_valid = r_feed_valid;
  assign feed_ir    = r_feed_ir;
  assign feed_k     = r_feed_k;
  assign feed_pc    = r_feed_pc;
  assign feed_ack   = w_ack;

endmodule

// File: tb/tb_ir_feed.sv
// Directed self-checking bench for ir_feed with a zero-wait byte memory model.
module tb_ir_feed;

  logic        clk, a_rst;
  logic        mem_req, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        pc_load, hold_fetch, replace_ir, replace_k, feed_ready;
  logic [15:0] pc_new, int_ir, int_k;
  logic        feed_valid, feed_ack;
  logic [15:0] feed_ir, feed_k, feed_pc;

  logic [7:0]  mem [65536];
  logic        ack_en;
  int          checks, failures;

  assign mem_ack  = mem_req & ack_en;
  assign mem_data = mem[mem_addr];

  ir_feed #(.FIFO_DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .a_rst(a_rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .pc_load(pc_load), .pc_new(pc_new), .hold_fetch(hold_fetch),
    .replace_ir(replace_ir), .replace_k(replace_k), .int_ir(int_ir), .int_k(int_k),
    .feed_valid(feed_valid), .feed_ir(feed_ir), .feed_k(feed_k), .feed_pc(feed_pc),
    .feed_ready(feed_ready), .feed_ack(feed_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic get_word(output logic [15:0] ir, output logic [15:0] k,
                          output logic [15:0] pc, output bit got);
    got = 1'b0;
    ir = '0; k = '0; pc = '0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (feed_valid) begin
        ir = feed_ir; k = feed_k; pc = feed_pc; got = 1'b1;
      end
    end
  endtask

  task automatic redirect(input logic [15:0] target);
    @(negedge clk);
    pc_load = 1'b1; pc_new = target;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0000", mem_addr); end
    checks++; if (feed_valid !== 1'b0) begin failures++; $display("FAIL rst_feed_valid got=%b exp=0", feed_valid); end
    checks++; if ({feed_ir, feed_k, feed_pc} !== 48'h0) begin failures++; $display("FAIL rst_feed_regs got=%h/%h/%h exp=0", feed_ir, feed_k, feed_pc); end
  endtask

  task automatic test_linear;
    logic [15:0] ir, k, pc; bit got;
    @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin failures++; $display("FAIL lin_first_req got=%b@%h exp=1@0000", mem_req, mem_addr); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL lin_req_gap got=%b exp=0", mem_req); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0001) begin failures++; $display("FAIL lin_second_req got=%b@%h exp=1@0001", mem_req, mem_addr); end
    get_word(ir, k, pc, got);
    checks++;
    if (!got || ir !== 16'h00A9 || k !== 16'h0005 || pc !== 16'h0000) begin
      failures++; $display("FAIL lin_word0 got=%b %h/%h/%h exp=00A9/0005/0000", got, ir, k, pc);
    end
    get_word(ir, k, pc, got);
    checks++;
    if (!got || ir !== 16'h00EA || k !== 16'h0000 || pc !== 16'h0002) begin
      failures++; $display("FAIL lin_word1 got=%b %h/%h/%h exp=00EA/0000/0002", got, ir, k, pc);
    end
  endtask

  task automatic test_three_byte;
    logic [15:0] ir, k, pc; bit got;
    redirect(16'h1000);
    get_word(ir, k, pc, got);
    checks++; if (!got || ir !== 16'h004C) begin failures++; $display("FAIL jmp_ir got=%b %h exp=004C", got, ir); end
    checks++; if (k !== 16'h1234) begin failures++; $display("FAIL jmp_k got=%h exp=1234", k); end
    checks++; if (pc !== 16'h1000) begin failures++; $display("FAIL jmp_pc got=%h exp=1000", pc); end
  endtask

  task automatic test_redirect_drop;
    logic [15:0] ir, k, pc; bit got, found;
    @(negedge clk);
    pc_load = 1'b1; pc_new = 16'h3000;
    @(negedge clk);
    pc_load = 1'b0; ack_en = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h3000) begin failures++; $display("FAIL drop_pending got=%b@%h exp=1@3000", mem_req, mem_addr); end
    pc_load = 1'b1; pc_new = 16'h2000;
    @(negedge clk);
    pc_load = 1'b0; ack_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr !== 16'h3000) found = 1'b1;
    end
    checks++; if (!found || mem_addr !== 16'h2000) begin failures++; $display("FAIL drop_next_req got=%b@%h exp=1@2000", found, mem_addr); end
    get_word(ir, k, pc, got);
    checks++;
    if (!got || ir !== 16'h00E8 || k !== 16'h0000 || pc !== 16'h2000) begin
      failures++; $display("FAIL drop_word got=%b %h/%h/%h exp=00E8/0000/2000", got, ir, k, pc);
    end
  endtask

  task automatic test_inject;
    logic [15:0] ir, k, pc; bit got;
    int n;
    feed_ready = 1'b0; hold_fetch = 1'b1;
    redirect(16'h0300);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (mem_req) begin
        if (n < 2) n++;
        else begin ack_en = 1'b0; break; end
      end
      @(negedge clk);
    end
    @(negedge clk);
    hold_fetch = 1'b0; replace_ir = 1'b1; replace_k = 1'b1;
    int_ir = 16'h832A; int_k = 16'hFFFE;
    @(negedge clk);
    replace_ir = 1'b0; replace_k = 1'b0;
    checks++; if (feed_valid !== 1'b1) begin failures++; $display("FAIL inj_valid got=%b exp=1", feed_valid); end
    checks++; if (feed_ir !== 16'h832A || feed_k !== 16'hFFFE) begin failures++; $display("FAIL inj_word got=%h/%h exp=832A/FFFE", feed_ir, feed_k); end
    checks++; if (feed_pc !== 16'h0300) begin failures++; $display("FAIL inj_pc got=%h exp=0300", feed_pc); end
    feed_ready = 1'b1;
    get_word(ir, k, pc, got);
    checks++;
    if (!got || ir !== 16'h00A2 || k !== 16'h007F || pc !== 16'h0300) begin
      failures++; $display("FAIL inj_native_after got=%b %h/%h/%h exp=00A2/007F/0300", got, ir, k, pc);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_hold;
    logic [15:0] ir, k, pc; bit got, stayed;
    feed_ready = 1'b0; hold_fetch = 1'b0;
    redirect(16'h0400);
    repeat (20) @(negedge clk);
    checks++; if (feed_valid !== 1'b1 || feed_ir !== 16'h00E8 || feed_pc !== 16'h0400) begin failures++; $display("FAIL hold_pending got=%b %h@%h exp=1 00E8@0400", feed_valid, feed_ir, feed_pc); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL hold_full_noreq got=%b exp=0", mem_req); end
    hold_fetch = 1'b1; feed_ready = 1'b1;
    #1;
    checks++; if (feed_ack !== 1'b1) begin failures++; $display("FAIL hold_ack got=%b exp=1", feed_ack); end
    stayed = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (feed_valid !== 1'b0) stayed = 1'b0;
    end
    checks++; if (!stayed) begin failures++; $display("FAIL hold_blocks got=valid exp=no_valid"); end
    hold_fetch = 1'b0;
    get_word(ir, k, pc, got);
    checks++;
    if (!got || ir !== 16'h00C8 || k !== 16'h0000 || pc !== 16'h0401) begin
      failures++; $display("FAIL hold_release got=%b %h/%h/%h exp=00C8/0000/0401", got, ir, k, pc);
    end
  endtask

  task automatic test_wrap;
    logic [15:0] ir, k, pc; bit got, found;
    mem[16'hFFFF] = 8'h20; mem[16'h0000] = 8'hCD; mem[16'h0001] = 8'hAB; mem[16'h0002] = 8'hEA;
    feed_ready = 1'b0;
    redirect(16'hFFFF);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr === 16'h0000) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL wrap_addr got=no_req_at_0000 exp=req_at_0000"); end
    feed_ready = 1'b1;
    get_word(ir, k, pc, got);
    checks++;
    if (!got || ir !== 16'h0020 || k !== 16'hABCD || pc !== 16'hFFFF) begin
      failures++; $display("FAIL wrap_word got=%b %h/%h/%h exp=0020/ABCD/FFFF", got, ir, k, pc);
    end
    get_word(ir, k, pc, got);
    checks++;
    if (!got || ir !== 16'h00EA || pc !== 16'h0002) begin
      failures++; $display("FAIL wrap_next got=%b %h@%h exp=00EA@0002", got, ir, pc);
    end
  endtask

  task automatic test_reset_mid_request;
    bit found;
    ack_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_req) found = 1'b1;
    end
    a_rst = 1'b0;
    #1;
    checks++; if (!found || mem_req !== 1'b0) begin failures++; $display("FAIL rst_mid_req got=%b/%b exp=1/0", found, mem_req); end
    checks++; if (mem_addr !== 16'h0000 || feed_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_state got=%h/%b exp=0000/0", mem_addr, feed_valid); end
  endtask

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'h0000] = 8'hA9; mem[16'h0001] = 8'h05; mem[16'h0002] = 8'hEA;
    mem[16'h1000] = 8'h4C; mem[16'h1001] = 8'h34; mem[16'h1002] = 8'h12;
    mem[16'h2000] = 8'hE8;
    mem[16'h0300] = 8'hA2; mem[16'h0301] = 8'h7F; mem[16'h0302] = 8'hE8;
    mem[16'h0400] = 8'hE8; mem[16'h0401] = 8'hC8;
    ack_en = 1'b1; pc_load = 1'b0; pc_new = '0; hold_fetch = 1'b0;
    replace_ir = 1'b0; replace_k = 1'b0; int_ir = '0; int_k = '0; feed_ready = 1'b1;
    a_rst = 1'b1;
    #2 a_rst = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    test_linear;
    test_three_byte;
    test_redirect_drop;
    test_inject;
    test_hold;
    test_wrap;
    test_reset_mid_request;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ir_feed.md
# ir_feed

Instruction feed stage that sits directly upstream of decode and the CPU status sequencer. It prefetches opcode and operand bytes from the memory port into a small byte FIFO, assembles complete 6502/65C02 instructions into a 16-bit IR / 16-bit K word, and presents one word at a time to decode. It also injects the sequencer's synthetic interrupt word (`int_ir`/`int_k`) on `replace_ir`, honours `hold_fetch`, and returns `feed_ack` to the sequencer.

## Interface
- `FIFO_DEPTH`, 4: byte FIFO depth, power of two, ≥3.
- `RESET_PC`, 16'h0000: fetch address after reset.

- `clk`  in  1  clock, rising edge
- `a_rst`  in  1  reset, asynchronous, active-low
- `mem_req`  out  1  fetch request
- `mem_addr`  out  16  fetch byte address
- `mem_ack`  in  1  request complete; `mem_data` valid this cycle
- `mem_data`  in  8  fetched byte
- `pc_load`  in  1  redirect fetch (branch/jump/vector)
- `pc_new`  in  16  redirect target
- `hold_fetch`  in  1  block new native words into the output register
- `replace_ir`  in  1  inject `int_ir` into the output register
- `replace_k`  in  1  inject `int_k`; driven identically to `replace_ir`
- `int_ir`  in  16  synthetic IR
- `int_k`  in  16  synthetic K
- `feed_valid`  out  1  output word valid
- `feed_ir`  out  16  IR: native = {8'h00, opcode}; injected = `int_ir` verbatim
- `feed_k`  out  16  operand {hi, lo}, zero-extended; 0 for 1-byte ops
- `feed_pc`  out  16  address of the opcode byte; for an injected word, the address of the next native opcode
- `feed_ready`  in  1  decode accepts the word
- `feed_ack`  out  1  word consumed

## Operation
- **Fetch FSM** has two states.
  - RUN: issue a request when `fifo_count + outstanding < FIFO_DEPTH`. Hold `mem_req` high with `mem_addr` stable until `mem_ack`. Allow one request outstanding. On ack, push the byte and increment `mem_addr` (wraps FFFF→0000).
  - DROP: entered on `pc_load` while a request is outstanding. Wait for `mem_ack`, discard the byte, return to RUN.
- **`pc_load`**: flush the FIFO, set `mem_addr` and `head_pc` to `pc_new`, and clear `feed_valid`, except when `replace_ir` is active in the same cycle (see injection).
- **Length decode** (opcode = FIFO head):
  - 3 bytes: `op[3:2]==2'b11`, or `op[4:0]==5'b11001`, or `op==8'h20`, or low nibble F.
  - 1 byte: low nibble 8, A, 3 or B, or `op` ∈ {40, 60}.
  - All other opcodes: 2 bytes. BRK (00) is 2 bytes.
- **Native load**: condition is `!hold_fetch && !replace_ir && fifo_count ≥ len && (!feed_valid || feed_ack)`. On load, pop `len` bytes, write IR/K/PC, and advance `head_pc` by `len`.
- **Injection**: `replace_ir` loads `int_ir`/`int_k` and `feed_pc = head_pc`, and sets `feed_valid`. It overrides the native load and any pending word. FIFO, `head_pc` and the outstanding fetch are untouched. If `pc_load` is asserted in the same cycle, the FIFO flush still happens.
- **`feed_ack`** = `feed_valid & feed_ready & ~pc_load`, combinational. When `feed_ack` is high without a reload, `feed_valid` clears.
- While `hold_fetch` is high, a word already in the output register can still be consumed and acked. FIFO prefetch continues.

## Timing
- **Reset values**: `mem_req` 0, `mem_addr` = `RESET_PC`, `feed_valid` 0, `feed_ir`/`feed_k`/`feed_pc` 0, FIFO empty, FSM RUN.
- `mem_req` rises one cycle after reset release or after `pc_load` (when no request is outstanding).
- `mem_ack` at cycle N: byte is in the FIFO at N+1. A 1-byte op then shows `feed_valid` at N+2.
- Back-to-back requests: next `mem_req` is one cycle after `mem_ack` (one byte per 2 cycles with zero-wait memory).
- Output register throughput is one word per cycle when the FIFO holds enough bytes.
- `replace_ir` at cycle N: `feed_valid` with `int_ir` at N+1.
- FIFO full: no request. FIFO empty: no native load.
- Reset mid-request drops the request immediately.

## Structure
- Shared package `cpu_pkg`: `op_len_t` (2-bit), `INT_IR_NATIVE_HI = 8'h00`, fetch FSM state encoding.
- One sub-module `op_len_decode` (8-bit opcode → length 1..3, combinational). FIFO is inline in `ir_feed`.

## Test plan
- **Reset then linear fetch**: memory at 0000 = A9 05 EA, 0-wait → words {0x00A9, K 0x0005, PC 0000} and {0x00EA, K 0, PC 0002}.
- **3-byte op**: `pc_load` 0x1000, bytes 4C 34 12 → `feed_ir` 0x004C, `feed_k` 0x1234, `feed_pc` 0x1000.
- **Redirect during outstanding request**: `pc_load` 0x2000 while `mem_req` is waiting → the late byte is discarded; the next request is to 0x2000.
- **Injection**: `replace_ir` with `int_ir` 0x832A, `int_k` 0xFFFE while the FIFO holds 2 bytes at 0x0300 → word {0x832A, 0xFFFE, PC 0x0300}; the FIFO bytes are presented after `feed_ack`.
- **hold_fetch**: FIFO full and `hold_fetch` high → pending word acked once, then `feed_valid` stays 0 until `hold_fetch` falls.
- **Wrap**: `pc_load` 0xFFFF, op 20 with bytes at FFFF/0000/0001 → `mem_addr` wraps to 0000, K assembled correctly, next `head_pc` = 0x0002.
